bin_to_7seg_scan: RTL
=====================

Name: bin_to_7seg_scan

Overview:
- Parametrised successor to the single-nibble two-digit display path.
- Converts an IN_WIDTH-bit unsigned binary value to N_DIGITS BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed common-anode 7-segment bank, with leading-zero blanking, overflow indication and a display enable.
- Sits between datapath results, such as the Gray decoder output, and the board display pins.

Parameters:
- IN_WIDTH, 14, width of the binary input value (1..32).
- N_DIGITS, 4, number of display digits driven (1..8).
- CLK_HZ, 100000000, clk frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. Divider terminal count is CLK_HZ/SCAN_HZ, which must be ≥ 2.
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  IN_WIDTH  unsigned binary value to display.
- en  in  1  1 = display on; 0 = all anodes off (conversion keeps running).
- digit_en  out  N_DIGITS  anode enables, active-low. Bit 0 = units (rightmost).
- cSeg  out  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- done  out  1  one-cycle pulse when a new conversion is committed to the display register.
- overflow  out  1  registered: 1 while the committed value exceeds 10^N_DIGITS-1.

Behaviour:
- Reset values: rst_n=0 forces all of the following immediately:
  - digit_en = all 1s; cSeg = 7'h7F; done = 0; overflow = 0.
  - Display register = 0; scan index = 0; divider = 0; FSM = IDLE.
- Converter FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: capture `in` into the shift register, clear the BCD accumulator (4*N_DIGITS bits), set bit counter = IN_WIDTH. Go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1 and decrement the counter. When the counter reaches 1, the shift that cycle is the last one; go to COMMIT.
  - COMMIT: load the display register with the BCD result, set `overflow` from the captured value > 10^N_DIGITS-1, pulse done=1. Go to IDLE.
- Free-running. The conversion period is IN_WIDTH+2 cycles. `in` is sampled only in IDLE, so changes mid-conversion appear in the next conversion.
- Input-to-display latency: IN_WIDTH+2 cycles from the capture edge to the display register update. Up to 2*(IN_WIDTH+2) cycles worst-case from any input change.
- BCD bits above the carry-out of the top digit are discarded. Overflow display is therefore independent of the truncated BCD.
- Scan divider:
  - Counts 0..CLK_HZ/SCAN_HZ-1, then wraps to 0.
  - At the wrap, the scan index advances; index N_DIGITS-1 wraps to 0.
  - Exactly one digit is active per scan slot.
- Output stage, registered with 1 cycle of latency from the scan index and display register:
  - en=0: digit_en all 1s, cSeg = 7'h7F.
  - overflow=1: every digit shows a dash (cSeg = 7'h3F, segment g only).
  - Otherwise, digit k shows the decoded BCD nibble k. Nibble values 10–15 cannot occur; if they did, the digit is blanked.
  - BLANK_LZ=1: digit k>0 is blanked (its anode is still enabled, cSeg = 7'h7F) when nibble k and all higher nibbles are 0. Digit 0 is always shown, so a value of 0 displays "0".
- Segment codes, active-low, for digits 0–9: 40,79,24,30,19,12,02,78,00,10 (hex).
- Simultaneous events:
  - A COMMIT on the same cycle as a scan advance: the output uses the new display register on the following cycle. No torn digit is allowed, because the display register updates atomically.
  - Reset mid-conversion discards the partial result. After release, the display shows 0 until the first COMMIT.
- No combinational path from `in` to any output.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=8, SCAN_HZ=1 (scan slot = 8 cycles).
- Reset then release with in=0: done every 16 cycles (IN_WIDTH=14). Digit 0 shows cSeg=40. Digits 1–3 are blanked (7F). digit_en cycles 1110→1101→1011→0111 every 8 cycles.
- in=1234: after the second done, digit 3..0 show 79,24,30,19. Display register updates exactly 16 cycles after the capture cycle.
- in=9999 → all digits 10 (hex). in=10000 → overflow=1 and all digits 3F. in back to 5 → overflow=0, digit 0 = 12, higher digits 7F.
- BLANK_LZ=0 with in=7 → digits 3..0 show 40,40,40,78.
- en=0 during scanning → digit_en=1111 and cSeg=7F on the next cycle. Conversions continue (done pulses persist). en=1 restores the scan at the current index.
- Assert rst_n mid-SHIFT with in=4321 → outputs go to reset values immediately. After release, first done at cycle 16, then 4321 is displayed.

Source files
------------

// File: rtl/bin_to_7seg_scan.sv
// Binary to multiplexed common-anode 7-segment display driver.
// A free-running double-dabble engine converts `in` to BCD once every IN_WIDTH+2 cycles and
// commits the result atomically to a display register. A scan divider then walks the digits,
// one per scan slot. The output stage is fully registered, so there is no combinational path
// from `in` to any pin.
module bin_to_7seg_scan #(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] in,
  input  logic                en,
  output logic [N_DIGITS-1:0] digit_en,
  output logic [6:0]          cSeg,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned BcdW    = 4 * N_DIGITS;
  localparam int unsigned CntW    = $clog2(IN_WIDTH + 1);
  localparam int unsigned TermCnt = CLK_HZ / SCAN_HZ;
  localparam int unsigned DivW    = $clog2(TermCnt);
  localparam int unsigned IdxW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Largest value the digit bank can show; anything above it is drawn as dashes.
  localparam longint unsigned MaxDisp = pow10(N_DIGITS) - 1;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic [BcdW-1:0]       bcd_adj;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]       disp_q, disp_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;

  logic [DivW-1:0]       div_q, div_d;
  logic [IdxW-1:0]       idx_q, idx_d;

  logic [N_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [6:0]            cseg_q, cseg_d;
  logic [3:0]            cur_nib;
  logic                  upper_zero;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more before shifting.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Converter next state: capture, IN_WIDTH shift steps, then commit to the display register.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        bin_d      = in;
        bcd_d      = '0;
        cnt_d      = CntW'(IN_WIDTH);
        // The shift register is consumed by the conversion, so judge overflow at capture.
        ovf_pend_d = (64'(in) > MaxDisp);
        state_d    = StShift;
      end
      StShift: begin
        // The top BCD bit falls off here; overflow is tracked separately.
        bcd_d = {bcd_adj[BcdW-2:0], bin_q[IN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        disp_d     = bcd_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Scan divider and digit index: advance one digit per divider wrap.
  always_comb begin
    div_d = div_q + DivW'(1);
    idx_d = idx_q;
    if (div_q == DivW'(TermCnt - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Scan registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Leading-zero detect: true when the current nibble and every higher nibble are zero.
  always_comb begin
    cur_nib    = disp_q[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if ((IdxW'(k) >= idx_q) && (disp_q[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Output stage next values: enable gating, overflow dashes, blanking, then digit decode.
  always_comb begin
    digit_en_d = '1;
    cseg_d     = 7'h7F;
    if (en) begin
      digit_en_d = ~(N_DIGITS'(1) << idx_q);
      if (overflow_q) begin
        cseg_d = 7'h3F;
      end else if ((BLANK_LZ != 0) && (idx_q != '0) && upper_zero) begin
        cseg_d = 7'h7F;
      end else begin
        cseg_d = seg_decode(cur_nib);
      end
    end
  end

  // Output registers; reset leaves every anode and segment dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en_q <= '1;
      cseg_q     <= 7'h7F;
    end else begin
      digit_en_q <= digit_en_d;
      cseg_q     <= cseg_d;
    end
  end

  assign digit_en = digit_en_q;
  assign cSeg     = cseg_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
